// File: rtl/enum_rr_arbiter.sv
// Round-robin arbiter sharing one resource among four requesters.
// Enum-typed three-process FSM: IDLE -> GRANT -> HOLD -> (GAP) -> IDLE.
// The owner pointer is retained after release and serves as the round-robin base.
module enum_rr_arbiter #(
  parameter int unsigned MAX_HOLD   = 8,  // 1..255
  parameter int unsigned GAP_CYCLES = 1   // 0..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       forced,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    own0 = 2'd0,
    own1 = 2'd1,
    own2 = 2'd2,
    own3 = 2'd3
  } owner_t;

  arb_state_t state, state_nxt;
  owner_t     owner, winner;
  logic [1:0] cand;
  logic       found;
  logic [7:0] hold_cnt;
  logic [3:0] gap_cnt;
  logic       active;
  logic       timeout;
  logic       release_now;
  logic       forced_nxt;
  logic       prev_active;

  // Winner search: first set request bit starting just after the last owner.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = owner + 2'(i);
      if (!found && req[cand]) begin
        winner = owner_t'(cand);
        found  = 1'b1;
      end
    end
  end

  // Release qualification; a coincident done/withdraw suppresses the forced pulse.
  always_comb begin
    active      = (state == ST_GRANT) || (state == ST_HOLD);
    timeout     = (hold_cnt == 8'(MAX_HOLD));
    release_now = active && (done || !req[owner] || timeout);
    forced_nxt  = active && !done && req[owner] && timeout;
  end

  // State register, owner pointer and cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= own3;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      forced      <= 1'b0;
      prev_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      forced      <= forced_nxt;
      prev_active <= active;
      if (state == ST_IDLE && req != '0)
        owner <= winner;
      if (state_nxt == ST_GRANT)
        hold_cnt <= 8'd1;
      else if (state_nxt == ST_HOLD)
        hold_cnt <= hold_cnt + 8'd1;
      else
        hold_cnt <= '0;
      if (state_nxt == ST_GAP)
        gap_cnt <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd1;
      else
        gap_cnt <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req != '0) state_nxt = ST_GRANT;
      ST_GRANT,
      ST_HOLD: begin
        if (release_now)
          state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        else
          state_nxt = ST_HOLD;
      end
      ST_GAP:   if (gap_cnt >= 4'(GAP_CYCLES)) state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state and owner.
  always_comb begin
    busy    = (state == ST_GRANT) || (state == ST_HOLD);
    gnt     = busy ? (4'b0001 << owner) : '0;
    gnt_id  = owner;
    state_o = state;
  end

  // Combinational safety properties.
  always_comb begin
    assert ($onehot0(gnt));
    assert ((gnt != '0) == busy);
    assert (busy == (state_o == ST_GRANT || state_o == ST_HOLD));
    assert (ST_IDLE == '0);
    assert (own0 == '0);
  end

  // A forced pulse may only follow a cycle spent in GRANT or HOLD.
  always_ff @(posedge clk) begin
    if (!rst && forced)
      assert (prev_active);
  end

endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Self-checking bench: two arbiters (GAP_CYCLES=1 and GAP_CYCLES=0), each driven
// from a per-cycle vector table; expected outputs are queued when inputs are
// driven and compared one cycle later.
module tb_enum_rr_arbiter;

  localparam logic [1:0] SI = 2'd0, SG = 2'd1, SH = 2'd2, SP = 2'd3;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       forced;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    logic       sel;
    int         idx;
    logic [9:0] exp;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, done_a = 1'b0;
  logic [3:0] req_a = '0;
  logic [3:0] gnt_a;
  logic [1:0] id_a, st_a;
  logic       busy_a, forced_a;

  logic       rst_b = 1'b1, done_b = 1'b0;
  logic [3:0] req_b = '0;
  logic [3:0] gnt_b;
  logic [1:0] id_b, st_b;
  logic       busy_b, forced_b;

  enum_rr_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a), .forced(forced_a), .state_o(st_a)
  );

  enum_rr_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b), .forced(forced_b), .state_o(st_b)
  );

  vec_t va[$];
  vec_t vb[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic d, logic [3:0] g,
                              logic [1:0] id, logic b, logic f, logic [1:0] st);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.gnt = g;
    v.id = id; v.busy = b; v.forced = f; v.st = st;
    return v;
  endfunction

  // Drive one vector on the falling edge, check the result after the next rising edge.
  task automatic apply(input logic sel, input vec_t v, input int idx);
    sb_t e, got_e;
    logic [9:0] got;
    @(negedge clk);
    if (sel == 1'b0) begin rst_a = v.rst; req_a = v.req; done_a = v.done; end
    else             begin rst_b = v.rst; req_b = v.req; done_b = v.done; end
    e.sel = sel; e.idx = idx;
    e.exp = {v.gnt, v.id, v.busy, v.forced, v.st};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    got = (got_e.sel == 1'b0) ? {gnt_a, id_a, busy_a, forced_a, st_a}
                              : {gnt_b, id_b, busy_b, forced_b, st_b};
    n_cmp++;
    if (got !== got_e.exp) begin
      n_bad++;
      $display("FAIL %s[%0d] {gnt,id,busy,forced,state} got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
               got_e.sel ? "gap0" : "gap1", got_e.idx,
               got[9:6], got[5:4], got[3], got[2], got[1:0],
               got_e.exp[9:6], got_e.exp[5:4], got_e.exp[3], got_e.exp[2], got_e.exp[1:0]);
    end
  endtask

  initial begin
    logic [1:0] id;
    logic [3:0] oh;

    // ---------- table for GAP_CYCLES=1 ----------
    repeat (2) va.push_back(mk(1, 4'h0, 0, 4'h0, 2'd3, 0, 0, SI));
    // full contention, done one cycle into each hold
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      oh = 4'b0001 << id;
      va.push_back(mk(0, 4'hF, 0, oh,   id, 1, 0, SG));
      va.push_back(mk(0, 4'hF, 0, oh,   id, 1, 0, SH));
      va.push_back(mk(0, 4'hF, 1, 4'h0, id, 0, 0, SP));
      va.push_back(mk(0, 4'hF, 0, 4'h0, id, 0, 0, SI));
    end
    // lone requester 2 times out after exactly 8 granted cycles
    va.push_back(mk(0, 4'h4, 0, 4'h4, 2'd2, 1, 0, SG));
    repeat (7) va.push_back(mk(0, 4'h4, 0, 4'h4, 2'd2, 1, 0, SH));
    va.push_back(mk(0, 4'h4, 0, 4'h0, 2'd2, 0, 1, SP));
    va.push_back(mk(0, 4'h4, 0, 4'h0, 2'd2, 0, 0, SI));
    va.push_back(mk(0, 4'h4, 0, 4'h4, 2'd2, 1, 0, SG));
    va.push_back(mk(0, 4'h0, 0, 4'h0, 2'd2, 0, 0, SP));
    va.push_back(mk(0, 4'h0, 0, 4'h0, 2'd2, 0, 0, SI));
    // owner 1 withdraws its request
    va.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SG));
    va.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SH));
    va.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SH));
    va.push_back(mk(0, 4'h0, 0, 4'h0, 2'd1, 0, 0, SP));
    va.push_back(mk(0, 4'h0, 0, 4'h0, 2'd1, 0, 0, SI));
    // reset during HOLD, then priority restarts at requester 0
    va.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SG));
    va.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SH));
    va.push_back(mk(1, 4'h2, 0, 4'h0, 2'd3, 0, 0, SI));
    va.push_back(mk(0, 4'h3, 0, 4'h1, 2'd0, 1, 0, SG));
    va.push_back(mk(0, 4'h3, 1, 4'h0, 2'd0, 0, 0, SP));
    va.push_back(mk(0, 4'h0, 0, 4'h0, 2'd0, 0, 0, SI));
    // done coincident with timeout is a normal release
    va.push_back(mk(0, 4'h8, 0, 4'h8, 2'd3, 1, 0, SG));
    repeat (7) va.push_back(mk(0, 4'h8, 0, 4'h8, 2'd3, 1, 0, SH));
    va.push_back(mk(0, 4'h8, 1, 4'h0, 2'd3, 0, 0, SP));
    va.push_back(mk(0, 4'h8, 0, 4'h0, 2'd3, 0, 0, SI));
    va.push_back(mk(0, 4'h8, 0, 4'h8, 2'd3, 1, 0, SG));
    va.push_back(mk(0, 4'h0, 0, 4'h0, 2'd3, 0, 0, SP));

    // ---------- table for GAP_CYCLES=0 ----------
    repeat (2) vb.push_back(mk(1, 4'h0, 0, 4'h0, 2'd3, 0, 0, SI));
    // requesters 0 and 3 alternate, one idle cycle between grants
    for (int k = 0; k < 4; k++) begin
      id = (k % 2 == 0) ? 2'd0 : 2'd3;
      oh = 4'b0001 << id;
      vb.push_back(mk(0, 4'h9, 1, oh,   id, 1, 0, SG));
      vb.push_back(mk(0, 4'h9, 1, 4'h0, id, 0, 0, SI));
    end
    // timeout with no gap goes straight back to IDLE
    vb.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SG));
    repeat (7) vb.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SH));
    vb.push_back(mk(0, 4'h2, 0, 4'h0, 2'd1, 0, 1, SI));
    vb.push_back(mk(0, 4'h2, 0, 4'h2, 2'd1, 1, 0, SG));
    vb.push_back(mk(0, 4'h0, 0, 4'h0, 2'd1, 0, 0, SI));

    foreach (va[i]) apply(1'b0, va[i], i);
    @(negedge clk);
    rst_a = 1'b0; req_a = '0; done_a = 1'b0;
    foreach (vb[i]) apply(1'b1, vb[i], i);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
